// File: rtl/pulse_sync_pkg.sv
// Shared definitions for the multi-channel pulse synchroniser: mode codes,
// channel FSM states and the per-mode edge qualifier.
package pulse_sync_pkg;

    localparam logic [1:0] MODE_RISE = 2'b00;
    localparam logic [1:0] MODE_FALL = 2'b01;
    localparam logic [1:0] MODE_BOTH = 2'b10;
    localparam logic [1:0] MODE_OFF  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_HIGH = 2'b01,
        S_GAP  = 2'b10
    } state_e;

    function automatic logic edge_hit(input logic [1:0] mode, input logic s, input logic h);
        case (mode)
            MODE_RISE: edge_hit = s & ~h;
            MODE_FALL: edge_hit = ~s & h;
            MODE_BOTH: edge_hit = s ^ h;
            default:   edge_hit = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/pulse_sync_chan.sv
// One synchroniser channel: sync chain, edge detect, pulse/gap FSM,
// saturating pending-event counter and sticky overflow flag.
module pulse_sync_chan
    import pulse_sync_pkg::*;
#(
    parameter int SYNC_STAGES = 3,
    parameter int PULSE_W     = 1,
    parameter int GAP_W       = 1,
    parameter int CNT_W       = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       async_i,
    input  logic [1:0] mode_i,
    input  logic       armed_i,
    input  logic       ovf_clr_i,
    output logic       pulse_o,
    output logic       busy_o,
    output logic       overflow_o
);
    localparam int TMAX = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam logic [TW-1:0]    T_HIGH   = TW'(PULSE_W - 1);
    localparam logic [TW-1:0]    T_GAP    = TW'(GAP_W - 1);
    localparam logic [CNT_W-1:0] PEND_MAX = {CNT_W{1'b1}};

    (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] sync_q;
    logic             hist_q;
    logic             ev_q;
    state_e           state_q;
    logic [TW-1:0]    timer_q;
    logic [CNT_W-1:0] pend_q;
    logic [CNT_W-1:0] pend_d;
    logic             ovf_q;
    logic             ovf_d;
    logic             pulse_q;
    logic             busy_q;
    logic             gap_end_s;
    logic             deq_s;
    logic             queue_s;
    logic             drop_s;

    // Synchroniser chain, edge history and the registered per-mode event
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            hist_q <= 1'b0;
            ev_q   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
            hist_q <= sync_q[SYNC_STAGES-1];
            ev_q   <= armed_i & edge_hit(mode_i, sync_q[SYNC_STAGES-1], hist_q);
        end
    end

    assign gap_end_s = (state_q == S_GAP) && (timer_q == '0);
    assign deq_s     = gap_end_s && (pend_q != '0);
    // An event landing on a gap end with nothing queued is served directly, not queued.
    assign queue_s   = ev_q && (state_q != S_IDLE) && !(gap_end_s && (pend_q == '0));
    assign drop_s    = queue_s && !deq_s && (pend_q == PEND_MAX);

    // Pending counter and sticky overflow next state
    always_comb begin
        pend_d = pend_q;
        ovf_d  = drop_s | (ovf_q & ~ovf_clr_i);
        if (queue_s && !deq_s && !drop_s) begin
            pend_d = pend_q + CNT_W'(1);
        end else if (deq_s && !queue_s) begin
            pend_d = pend_q - CNT_W'(1);
        end else begin
            pend_d = pend_q;
        end
    end

    // Channel FSM with registered pulse and busy outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            pulse_q <= 1'b0;
            busy_q  <= 1'b0;
            pend_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            pend_q <= pend_d;
            ovf_q  <= ovf_d;
            case (state_q)
                S_IDLE: begin
                    if (ev_q) begin
                        state_q <= S_HIGH;
                        timer_q <= T_HIGH;
                        pulse_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end else begin
                        pulse_q <= 1'b0;
                        busy_q  <= (pend_d != '0);
                    end
                end
                S_HIGH: begin
                    busy_q <= 1'b1;
                    if (timer_q == '0) begin
                        state_q <= S_GAP;
                        timer_q <= T_GAP;
                        pulse_q <= 1'b0;
                    end else begin
                        timer_q <= timer_q - TW'(1);
                        pulse_q <= 1'b1;
                    end
                end
                S_GAP: begin
                    if (timer_q != '0) begin
                        timer_q <= timer_q - TW'(1);
                        pulse_q <= 1'b0;
                        busy_q  <= 1'b1;
                    end else if (ev_q || (pend_q != '0)) begin
                        state_q <= S_HIGH;
                        timer_q <= T_HIGH;
                        pulse_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= S_IDLE;
                        pulse_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    timer_q <= '0;
                    pulse_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign pulse_o    = pulse_q;
    assign busy_o     = busy_q;
    assign overflow_o = ovf_q;

endmodule

// File: rtl/pulse_sync_multi.sv
// N_CH independent pulse synchroniser channels sharing one post-reset arm counter.
// async_in needs a false-path / max-delay constraint in the implementation flow.
module pulse_sync_multi
    import pulse_sync_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int SYNC_STAGES = 3,
    parameter int PULSE_W     = 1,
    parameter int GAP_W       = 1,
    parameter int CNT_W       = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_CH-1:0]   async_in,
    input  logic [2*N_CH-1:0] mode,
    input  logic [N_CH-1:0]   ovf_clr,
    output logic [N_CH-1:0]   pulse_out,
    output logic [N_CH-1:0]   busy,
    output logic [N_CH-1:0]   overflow
);
    localparam int ARM_N = SYNC_STAGES + 1;
    localparam int AW    = $clog2(ARM_N + 1);

    logic [AW-1:0] arm_cnt_q;
    logic          armed_q;

    // Mask edge detection until the sync chains and history flops hold real levels
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arm_cnt_q <= '0;
            armed_q   <= 1'b0;
        end else if (!armed_q) begin
            arm_cnt_q <= arm_cnt_q + AW'(1);
            armed_q   <= (arm_cnt_q == AW'(ARM_N - 1));
        end else begin
            arm_cnt_q <= arm_cnt_q;
            armed_q   <= 1'b1;
        end
    end

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        pulse_sync_chan #(
            .SYNC_STAGES(SYNC_STAGES),
            .PULSE_W    (PULSE_W),
            .GAP_W      (GAP_W),
            .CNT_W      (CNT_W)
        ) u_chan (
            .clk       (clk),
            .rst_n     (rst_n),
            .async_i   (async_in[gi]),
            .mode_i    (mode[2*gi +: 2]),
            .armed_i   (armed_q),
            .ovf_clr_i (ovf_clr[gi]),
            .pulse_o   (pulse_out[gi]),
            .busy_o    (busy[gi]),
            .overflow_o(overflow[gi])
        );
    end

endmodule

// File: tb/tb_pulse_sync_multi.sv
// Scoreboard bench: three configurations of pulse_sync_multi, expected pulse
// start cycles queued per stream (instance*4+channel) when stimulus is driven.
module tb_pulse_sync_multi;
    localparam int LAT = 3 + 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [2:0][3:0] ain;
    logic [2:0][7:0] md;
    logic [2:0][3:0] clr;
    logic [3:0] po_a, po_b, po_c, bz_a, bz_b, bz_c, ov_a, ov_b, ov_c;
    logic [11:0] po_all, prev_po, ov_all;
    assign po_all = {po_c, po_b, po_a};
    assign ov_all = {ov_c, ov_b, ov_a};

    int pw_of  [3] = '{1, 2, 1};
    int gw_of  [3] = '{1, 3, 1};
    int max_of [3] = '{15, 15, 3};

    int exp_q [12][$];
    int free_at [12];
    int wstart [12];
    int npulse [12];
    logic [11:0] ovf_exp;
    logic last_drop;
    int cyc = 0;
    int n_tests = 0;
    int n_fail = 0;

    pulse_sync_multi #(.N_CH(4), .SYNC_STAGES(3), .PULSE_W(1), .GAP_W(1), .CNT_W(4)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .async_in(ain[0]), .mode(md[0]), .ovf_clr(clr[0]),
        .pulse_out(po_a), .busy(bz_a), .overflow(ov_a));
    pulse_sync_multi #(.N_CH(4), .SYNC_STAGES(3), .PULSE_W(2), .GAP_W(3), .CNT_W(4)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .async_in(ain[1]), .mode(md[1]), .ovf_clr(clr[1]),
        .pulse_out(po_b), .busy(bz_b), .overflow(ov_b));
    pulse_sync_multi #(.N_CH(4), .SYNC_STAGES(3), .PULSE_W(1), .GAP_W(1), .CNT_W(2)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .async_in(ain[2]), .mode(md[2]), .ovf_clr(clr[2]),
        .pulse_out(po_c), .busy(bz_c), .overflow(ov_c));

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic int count_ge(input int s, input int a);
        int n = 0;
        for (int i = 0; i < exp_q[s].size(); i++) if (exp_q[s][i] >= a) n++;
        return n;
    endfunction

    function automatic bit has_start(input int s, input int a);
        for (int i = 0; i < exp_q[s].size(); i++) if (exp_q[s][i] == a) return 1'b1;
        return 1'b0;
    endfunction

    // Event reaches the channel FSM at edge a; serve, queue or drop it.
    task automatic post_event(input int inst, input int ch);
        int s, a, st;
        s = inst * 4 + ch;
        a = cyc + LAT;
        if (count_ge(s, a) == max_of[inst] && !has_start(s, a)) begin
            ovf_exp[s] = 1'b1;
            last_drop  = 1'b1;
        end else begin
            st = (a > free_at[s]) ? a : free_at[s];
            exp_q[s].push_back(st);
            free_at[s] = st + pw_of[inst] + gw_of[inst];
        end
    endtask

    task automatic drive(input int inst, input int ch, input logic val);
        logic old, hit;
        logic [1:0] m;
        old = ain[inst][ch];
        m   = md[inst][2*ch +: 2];
        ain[inst][ch] = val;
        case (m)
            2'b00:   hit = val & ~old;
            2'b01:   hit = ~val & old;
            2'b10:   hit = val ^ old;
            default: hit = 1'b0;
        endcase
        last_drop = 1'b0;
        if (hit) post_event(inst, ch);
    endtask

    task automatic mon_stream(input int s, input logic p, input logic pp);
        int e;
        if (p && !pp) begin
            wstart[s] = cyc;
            npulse[s]++;
            if (exp_q[s].size() == 0) begin
                check_eq($sformatf("unexpected_pulse_s%0d", s), cyc, -1);
            end else begin
                e = exp_q[s].pop_front();
                check_eq($sformatf("pulse_start_s%0d", s), cyc, e);
            end
        end else if (!p && pp) begin
            check_eq($sformatf("pulse_width_s%0d", s), cyc - wstart[s], pw_of[s / 4]);
        end
    endtask

    // Pulse monitor: pops the scoreboard on every rising pulse edge
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_po <= '0;
        end else begin
            for (int s = 0; s < 12; s++) mon_stream(s, po_all[s], prev_po[s]);
            prev_po <= po_all;
        end
    end

    initial begin
        int n0, base0, clr_at, hits;
        int base [4];
        int cnt_exp [4] = '{1, 1, 2, 0};
        ain = '0; clr = '0; ovf_exp = '0; prev_po = '0;
        md[0] = 8'b11_10_01_00;
        md[1] = 8'b00_00_10_00;
        md[2] = 8'b00_00_10_10;
        for (int s = 0; s < 12; s++) begin
            free_at[s] = 0; wstart[s] = 0; npulse[s] = 0;
        end
        tick(3);
        check_eq("reset_pulse", int'(po_all), 0);
        check_eq("reset_busy", int'({bz_c, bz_b, bz_a}), 0);
        check_eq("reset_ovf", int'(ov_all), 0);
        rst_n = 1'b1;
        tick(8);

        // 1: latency and busy tail
        drive(0, 0, 1'b1);
        n0 = cyc;
        tick(LAT - 1);
        check_eq("t1_pulse_early", int'(po_a[0]), 0);
        tick(1);
        check_eq("t1_pulse_high", int'(po_a[0]), 1);
        check_eq("t1_busy_high", int'(bz_a[0]), 1);
        tick(1);
        check_eq("t1_pulse_low", int'(po_a[0]), 0);
        check_eq("t1_busy_gap", int'(bz_a[0]), 1);
        tick(1);
        check_eq("t1_busy_fall", int'(bz_a[0]), 0);
        check_eq("t1_cycle", cyc - n0, LAT + 2);
        drive(0, 0, 1'b0);
        tick(10);

        // 2: modes rise/fall/both/off, then mode change on static inputs
        for (int c = 0; c < 4; c++) base[c] = npulse[c];
        for (int c = 0; c < 4; c++) drive(0, c, 1'b1);
        tick(10);
        for (int c = 0; c < 4; c++) drive(0, c, 1'b0);
        tick(12);
        for (int c = 0; c < 4; c++) check_eq($sformatf("t2_count_ch%0d", c), npulse[c] - base[c], cnt_exp[c]);
        md[0] = 8'b10_10_10_10;
        tick(6);
        md[0] = 8'b11_10_01_00;
        tick(10);
        for (int c = 0; c < 4; c++) check_eq($sformatf("t2_modechg_ch%0d", c), npulse[c] - base[c], cnt_exp[c]);

        // 3: five rise events two cycles apart, PULSE_W=2 GAP_W=3
        base0 = npulse[4];
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, 1'b1); tick(1);
            drive(1, 0, 1'b0); tick(1);
        end
        tick(40);
        check_eq("t3_count", npulse[4] - base0, 5);
        check_eq("t3_ovf", int'(ov_b[0]), 0);

        // 4: burst into CNT_W=2 channel, clear, then clear coinciding with a drop
        for (int i = 0; i < 12; i++) begin
            drive(2, 0, ~ain[2][0]); tick(1);
        end
        tick(40);
        check_eq("t4_ovf_set", int'(ov_c[0]), int'(ovf_exp[8]));
        check_eq("t4_ovf_set_const", int'(ov_c[0]), 1);
        clr[2][0] = 1'b1; tick(1); clr[2][0] = 1'b0;
        ovf_exp[8] = 1'b0;
        check_eq("t4_ovf_clr", int'(ov_c[0]), 0);
        tick(5);
        clr_at = -1;
        for (int i = 0; i < 18; i++) begin
            clr[2][0] = (cyc == clr_at);
            if (clr_at >= 0 && cyc == clr_at + 1) check_eq("t4_set_wins", int'(ov_c[0]), 1);
            if (i < 12) begin
                drive(2, 0, ~ain[2][0]);
                if (last_drop && clr_at < 0) clr_at = cyc + LAT - 1;
            end
            tick(1);
        end
        clr[2][0] = 1'b0;
        tick(40);
        check_eq("t4_ovf_final", int'(ov_c[0]), int'(ovf_exp[8]));

        // 5: fill pending to max, then events exactly on gap-end dequeues
        hits = 0;
        for (int i = 0; i < 20; i++) begin
            if (count_ge(9, cyc + LAT) >= 3) break;
            drive(2, 1, ~ain[2][1]); tick(1);
        end
        for (int i = 0; i < 16; i++) begin
            if (count_ge(9, cyc + LAT) == 3 && has_start(9, cyc + LAT)) begin
                drive(2, 1, ~ain[2][1]);
                hits++;
            end
            tick(1);
        end
        tick(40);
        check_eq("t5_no_ovf", int'(ov_c[1]), 0);
        check_eq("t5_model_ovf", int'(ov_c[1]), int'(ovf_exp[9]));

        // 6: reset mid-HIGH with pending, level held high through release
        for (int i = 0; i < 4; i++) begin
            if (i == 0) n0 = cyc;
            drive(1, 1, ~ain[1][1]); tick(1);
        end
        tick(n0 + LAT + 5 - cyc);
        check_eq("t6_mid_high", int'(po_b[1]), 1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("t6_rst_pulse", int'(po_all), 0);
        check_eq("t6_rst_busy", int'({bz_c, bz_b, bz_a}), 0);
        check_eq("t6_rst_ovf", int'(ov_all), 0);
        for (int s = 0; s < 12; s++) begin
            exp_q[s].delete();
            free_at[s] = 0;
        end
        ovf_exp = '0;
        ain[0][0] = 1'b1;
        tick(3);
        rst_n = 1'b1;
        base0 = npulse[0];
        tick(15);
        check_eq("t6_no_pulse_on_release", npulse[0] - base0, 0);
        drive(0, 0, 1'b0);
        tick(3);
        drive(0, 0, 1'b1);
        tick(LAT);
        check_eq("t6_latency", int'(po_a[0]), 1);
        tick(10);

        for (int s = 0; s < 12; s++) check_eq($sformatf("leftover_s%0d", s), exp_q[s].size(), 0);
        check_eq("final_ovf", int'(ov_all), int'(ovf_exp));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
